// File: rtl/bifrost_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package : bifrost_pkg
// Brief   : Shared constants for the Bifrost register window. These are the
//           interrupt-controller register offsets and the data width. The
//           top level and the software header generator use the same values.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
package bifrost_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] IRQC_STATUS  = 3'd0;
  localparam logic [2:0] IRQC_PENDING = 3'd1;
  localparam logic [2:0] IRQC_MASK    = 3'd2;
  localparam logic [2:0] IRQC_MODE    = 3'd3;
  localparam logic [2:0] IRQC_VECTOR  = 3'd4;
  localparam logic [2:0] IRQC_FORCE   = 3'd5;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] lowest_set(input logic [DATA_W-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (v[i]) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bifrost_irqc_irq_sync.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : irq_sync
// Brief  : Two-flop synchroniser for one active-low interrupt source. A third
//          flop holds the previous synchronised sample for falling-edge
//          detection. All flops reset to 1, which is the idle state of the line.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module irq_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic src_n,
  output logic level,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Next-state for the synchroniser chain and the previous-sample flop
  always_comb begin
    sync1_d = src_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchroniser and previous-sample registers, idle-high after reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign level = ~sync2_q;
  assign fall  = prev_q & ~sync2_q;

endmodule
`default_nettype wire

// File: rtl/bifrost_irqc.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : bifrost_irqc
// Brief  : Interrupt controller for up to 8 active-low sources. It provides
//          per-channel level or edge mode, a mask, forced pending bits, and
//          one registered active-low IRQ. CPU writes are captured during the
//          access and committed once after the access ends.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module bifrost_irqc
  import bifrost_pkg::*;
#(
  parameter int               CHANNELS   = 3,
  parameter logic [DATA_W-1:0] MASK_RESET = 8'hFF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] src_n,
  input  logic                cs_n,
  input  logic                rw,
  input  logic [2:0]          addr,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                data_oe,
  output logic                irq_n
);

  localparam logic [DATA_W-1:0] CH_MASK = DATA_W'((1 << CHANNELS) - 1);

  logic [DATA_W-1:0] level;
  logic [DATA_W-1:0] fall;

  // One synchroniser per implemented channel; absent channels read as idle
  for (genvar i = 0; i < DATA_W; i++) begin : g_ch
    if (i < CHANNELS) begin : g_used
      irq_sync u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .src_n   (src_n[i]),
        .level   (level[i]),
        .fall    (fall[i])
      );
    end else begin : g_unused
      assign level[i] = 1'b0;
      assign fall[i]  = 1'b0;
    end
  end

  logic                wr_active;
  logic                cap_valid_q, cap_valid_d;
  logic [2:0]          cap_addr_q,  cap_addr_d;
  logic [DATA_W-1:0]   cap_data_q,  cap_data_d;
  logic                commit_q,    commit_d;

  assign wr_active = ~cs_n & ~rw;

  // Capture the latest address/data while the write is active. CPU data is
  // only valid late in phi2, so the last sample is the one that counts.
  always_comb begin
    cap_valid_d = cap_valid_q;
    cap_addr_d  = cap_addr_q;
    cap_data_d  = cap_data_q;
    commit_d    = 1'b0;
    if (wr_active) begin
      cap_valid_d = 1'b1;
      cap_addr_d  = addr;
      cap_data_d  = data_in;
    end else if (cap_valid_q) begin
      cap_valid_d = 1'b0;
      commit_d    = 1'b1;
    end
  end

  // Write-capture registers; reset discards any half-finished access
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_valid_q <= 1'b0;
      cap_addr_q  <= '0;
      cap_data_q  <= '0;
      commit_q    <= 1'b0;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_addr_q  <= cap_addr_d;
      cap_data_q  <= cap_data_d;
      commit_q    <= commit_d;
    end
  end

  logic [DATA_W-1:0] pend_q, pend_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] mode_q, mode_d;
  logic              irq_n_q, irq_n_d;
  logic [DATA_W-1:0] w1c;
  logic [DATA_W-1:0] force_set;

  // Register updates. Edge channels keep set-over-clear priority, and level
  // channels track the synchronised line.
  always_comb begin
    mask_d    = mask_q;
    mode_d    = mode_q;
    w1c       = '0;
    force_set = '0;
    if (commit_q) begin
      case (cap_addr_q)
        IRQC_MASK:    mask_d    = cap_data_q & CH_MASK;
        IRQC_MODE:    mode_d    = cap_data_q & CH_MASK;
        IRQC_PENDING: w1c       = cap_data_q;
        IRQC_FORCE:   force_set = cap_data_q;
        default:      ;
      endcase
    end
    pend_d  = CH_MASK & ((mode_q & (fall | force_set | (pend_q & ~w1c)))
                       | (~mode_q & level));
    irq_n_d = ~|(pend_q & mask_q);
  end

  // Interrupt state and the registered IRQ output
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q  <= '0;
      mask_q  <= MASK_RESET & CH_MASK;
      mode_q  <= '0;
      irq_n_q <= 1'b1;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      irq_n_q <= irq_n_d;
    end
  end

  logic [DATA_W-1:0] active;
  assign active = pend_q & mask_q;

  // Side-effect-free read mux
  always_comb begin
    data_out = '0;
    case (addr)
      IRQC_STATUS:  data_out = level;
      IRQC_PENDING: data_out = pend_q;
      IRQC_MASK:    data_out = mask_q;
      IRQC_MODE:    data_out = mode_q;
      IRQC_VECTOR:  data_out = (|active) ? {1'b1, 4'b0000, lowest_set(active)} : '0;
      default:      data_out = '0;
    endcase
  end

  assign data_oe = ~cs_n & rw;
  assign irq_n   = irq_n_q;

endmodule
`default_nettype wire

// File: tb/tb_bifrost_irqc.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_bifrost_irqc
// Brief  : Self-checking bench for bifrost_irqc. It runs directed scenarios,
//          then random traffic checked against a sample-history reference model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_bifrost_irqc;
  import bifrost_pkg::*;

  localparam int         CH  = 3;
  localparam logic [7:0] CHM = 8'h07;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b1;
  logic [CH-1:0] src_n   = '1;
  logic          cs_n    = 1'b1;
  logic          rw      = 1'b1;
  logic [2:0]    addr    = '0;
  logic [7:0]    data_in = '0;
  logic [7:0]    data_out;
  logic          data_oe;
  logic          irq_n;

  always #5 clock = ~clock;

  bifrost_irqc #(.CHANNELS(CH), .MASK_RESET(8'hFF)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .src_n    (src_n),
    .cs_n     (cs_n),
    .rw       (rw),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .irq_n    (irq_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. hist[k] is the src_n value sampled k edges ago. The
  // visible level lags two edges, and an edge is a 1->0 step in that history.
  logic [CH-1:0] hist[$];
  logic [7:0] m_pend, m_mask, m_mode;
  logic       m_irq;
  logic       m_act, m_commit;
  logic [2:0] m_cap_a;
  logic [7:0] m_cap_d;
  logic [7:0] t_lvl, t_fall, t_clr, t_frc, t_np;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist = {};
      repeat (4) hist.push_back('1);
      m_pend = 8'h00; m_mask = CHM; m_mode = 8'h00; m_irq = 1'b1;
      m_act = 1'b0; m_commit = 1'b0; m_cap_a = '0; m_cap_d = '0;
    end else begin
      hist.push_front(src_n);
      void'(hist.pop_back());
      t_lvl  = {{(8-CH){1'b0}}, ~hist[2]};
      t_fall = {{(8-CH){1'b0}}, hist[3] & ~hist[2]};
      t_clr  = (m_commit && m_cap_a == IRQC_PENDING) ? m_cap_d : 8'h00;
      t_frc  = (m_commit && m_cap_a == IRQC_FORCE)   ? m_cap_d : 8'h00;
      m_irq  = ~|(m_pend & m_mask);
      t_np   = 8'h00;
      for (int c = 0; c < CH; c++)
        t_np[c] = m_mode[c] ? (t_fall[c] | t_frc[c] | (m_pend[c] & ~t_clr[c])) : t_lvl[c];
      m_pend = t_np;
      if (m_commit && m_cap_a == IRQC_MASK) m_mask = m_cap_d & CHM;
      if (m_commit && m_cap_a == IRQC_MODE) m_mode = m_cap_d & CHM;
      m_commit = 1'b0;
      if (!cs_n && !rw) begin
        m_act = 1'b1; m_cap_a = addr; m_cap_d = data_in;
      end else if (m_act) begin
        m_act = 1'b0; m_commit = 1'b1;
      end
    end
  end

  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    logic [7:0] pm;
    logic [2:0] idx;
    pm  = m_pend & m_mask;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (pm[i]) idx = i[2:0];
    case (a)
      IRQC_STATUS:  return {{(8-CH){1'b0}}, ~hist[1]};
      IRQC_PENDING: return m_pend;
      IRQC_MASK:    return m_mask;
      IRQC_MODE:    return m_mode;
      IRQC_VECTOR:  return (|pm) ? {1'b1, 4'b0000, idx} : 8'h00;
      default:      return 8'h00;
    endcase
  endfunction

  // Continuous comparison against the model away from the active edge
  always @(negedge clock) begin
    if (reset_n) begin
      check("irq_model", {7'b0, irq_n}, {7'b0, m_irq});
      check("data_oe", {7'b0, data_oe}, {7'b0, (~cs_n & rw)});
      if (!cs_n && rw) check("read_model", data_out, exp_rd(addr));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input int len);
    cs_n = 1'b0; rw = 1'b0; addr = a; data_in = d;
    repeat (len) step();
    cs_n = 1'b1; rw = 1'b1;
    step();
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    cs_n = 1'b0; rw = 1'b1; addr = a;
    @(negedge clock);
    check(tag, data_out, exp);
    step();
    cs_n = 1'b1;
  endtask

  initial begin
    #2 reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Reset values
    check("reset_irq", {7'b0, irq_n}, 8'h01);
    rd_chk("reset_mask", IRQC_MASK, 8'h07);
    rd_chk("reset_pend", IRQC_PENDING, 8'h00);
    rd_chk("reset_mode", IRQC_MODE, 8'h00);
    rd_chk("reset_vec", IRQC_VECTOR, 8'h00);

    // Level mode latency on channel 1
    src_n[1] = 1'b0;
    repeat (3) step();
    check("lvl_irq_e3", {7'b0, irq_n}, 8'h01);
    step();
    check("lvl_irq_e4", {7'b0, irq_n}, 8'h00);
    rd_chk("lvl_vec", IRQC_VECTOR, 8'h81);
    src_n[1] = 1'b1;
    repeat (3) step();
    check("lvl_rel_e3", {7'b0, irq_n}, 8'h00);
    step();
    check("lvl_rel_e4", {7'b0, irq_n}, 8'h01);

    // Edge mode on channel 2: pulse latches, W1C clears
    wr(IRQC_MODE, 8'h04, 1);
    step();
    src_n[2] = 1'b0;
    repeat (3) step();
    src_n[2] = 1'b1;
    repeat (5) step();
    rd_chk("edge_pend", IRQC_PENDING, 8'h04);
    wr(IRQC_PENDING, 8'h04, 1);
    step();
    rd_chk("w1c_pend", IRQC_PENDING, 8'h00);
    check("w1c_irq_e3", {7'b0, irq_n}, 8'h01);

    // Edge detected on the same edge as its W1C commit: set wins
    repeat (2) step();
    src_n[2] = 1'b0;
    wr(IRQC_PENDING, 8'h04, 1);
    step();
    rd_chk("set_wins", IRQC_PENDING, 8'h04);
    src_n[2] = 1'b1;
    repeat (4) step();
    wr(IRQC_PENDING, 8'h04, 1);
    step();

    // Long write: only the last sample commits, one cycle after cs_n rises
    cs_n = 1'b0; rw = 1'b0; addr = IRQC_MASK; data_in = 8'h00;
    repeat (9) step();
    data_in = 8'h01;
    step();
    cs_n = 1'b1; rw = 1'b1;
    step();
    check("hs_before", dut.mask_q, 8'h07);
    step();
    rd_chk("hs_mask", IRQC_MASK, 8'h01);

    // Everything masked with all sources low
    wr(IRQC_MASK, 8'h00, 2);
    src_n = '0;
    repeat (6) step();
    check("masked_irq", {7'b0, irq_n}, 8'h01);
    rd_chk("masked_status", IRQC_STATUS, 8'h07);
    src_n = '1;
    repeat (4) step();

    // FORCE only affects edge channels
    wr(IRQC_MODE, 8'h01, 1);
    wr(IRQC_PENDING, 8'h07, 1);
    wr(IRQC_FORCE, 8'h07, 1);
    step();
    rd_chk("force_pend", IRQC_PENDING, 8'h01);
    wr(IRQC_PENDING, 8'h01, 1);

    // Reset during a write discards the capture
    cs_n = 1'b0; rw = 1'b0; addr = IRQC_MASK; data_in = 8'h02;
    repeat (2) step();
    reset_n = 1'b0;
    step();
    cs_n = 1'b1; rw = 1'b1;
    step();
    reset_n = 1'b1;
    repeat (3) step();
    rd_chk("rst_mid_mask", IRQC_MASK, 8'h07);
    wr(IRQC_MASK, 8'h05, 1);
    step();
    rd_chk("post_rst_wr", IRQC_MASK, 8'h05);
    wr(IRQC_MASK, 8'h07, 1);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) src_n = CH'($urandom);
      case ($urandom_range(0, 3))
        0, 1: begin
          cs_n = 1'b0; rw = 1'b1; addr = 3'($urandom);
          step();
          cs_n = 1'b1;
        end
        2: wr(3'($urandom), 8'($urandom), $urandom_range(1, 3));
        default: step();
      endcase
    end
    src_n = '1;
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bifrost_irqc.md
# bifrost_irqc

Parametrised interrupt controller for the Bifröst CPLD glue, successor to the fixed AND-combine of VIA/UART IRQ lines. Accepts up to 8 active-low interrupt sources, synchronises them, latches edge-mode events, applies a CPU-writable mask and drives one registered active-low IRQ to the 6502. Sits behind the Bifröst register window (bifrost chip select), register offsets 0–5.

## Interface
- CHANNELS, default 3, number of sources (1..8); channel 0 = VIA1, 1 = VIA2, 2 = UART.
- MASK_RESET, default 8'hFF, reset value of MASK (all enabled, matching legacy behaviour).
- clock  in  1  fabric clock; every register samples on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- src_n  in  CHANNELS  raw interrupt sources, active-low, asynchronous.
- cs_n  in  1  register-window select, active-low.
- rw  in  1  6502 R/W (1 = read).
- addr  in  3  register offset.
- data_in  in  8  CPU write data.
- data_out  out  8  read data; combinational from registers.
- data_oe  out  1  = ~cs_n & rw; top level drives the data bus tristate from this.
- irq_n  out  1  registered combined interrupt to the CPU, active-low.

## Operation
- Registers; bits >= CHANNELS read 0, writes to them are ignored:
  - 0 STATUS (R): synchronised source levels, active-high.
  - 1 PENDING (R; W1C, edge channels only).
  - 2 MASK (RW, 1 = enabled); reset MASK_RESET & channel bits.
  - 3 MODE (RW, 1 = edge, 0 = level); reset 0.
  - 4 VECTOR (R): bit7 = any (PENDING & MASK); bits[2:0] = lowest-numbered such channel; all 0 if none.
  - 5 FORCE (W): sets PENDING bits of edge channels; level channels ignored.
  - 6, 7: read 8'h00; writes ignored.
- Per channel: 2-flop synchroniser, then falling-edge detect against a third (previous) flop.
- Level channel: PENDING <= synchronised level each cycle.
- Edge channel: PENDING is set by a detected falling edge or FORCE, cleared by W1C. If set and clear hit the same cycle, set wins.
- MODE edge->level: PENDING follows the level from the next cycle. Level->edge: PENDING holds its current value until W1C.
- irq_n <= ~|(PENDING & MASK) each cycle.
- Reads have no side effects.
- Write handshake:
  - write-active = ~cs_n & ~rw.
  - While write-active, addr and data_in are sampled every cycle.
  - On the first cycle write-active drops, the last sample is committed once.
  - Exactly one commit per access regardless of access length, because CPU data is valid only late in phi2.

## Timing
- Reset: PENDING = 0, MODE = 0, MASK = MASK_RESET, all synchroniser and previous flops = 1 (idle), write-capture cleared, irq_n = 1, data_out reflects reset registers.
- Source fall to PENDING: 3 rising edges. Source fall to irq_n low: 4 edges. Same latency in both modes.
- Write commit: register updated at the edge after the one where write-active is first seen low. irq_n reflects the new MASK/PENDING one edge later.
- Reset asserted mid-write: the captured write is discarded. The first access after release behaves normally.
- A source pulse shorter than one clock period may be missed; the minimum guaranteed pulse is 2 clocks.

## Structure
- Shared package bifrost_pkg holds the register offset constants (IRQC_STATUS ... IRQC_FORCE) and the data width constant 8. The Bifröst top level and the software header generator use the same values.
- Sub-module irq_sync: per-channel synchroniser plus falling-edge detect, outputs level and edge. Instantiated CHANNELS times with a generate loop.
- Replaces the inline combinational irq assignment in the top level. irq output = irq_n.

## Test plan
- Reset with CHANNELS=3: irq_n=1; reads give MASK=8'h07, PENDING=0, MODE=0, VECTOR=8'h00.
- Level mode: src_n[1]=0 -> irq_n low exactly 4 edges later; VECTOR=8'h81. Release the source -> irq_n high 4 edges later.
- Edge mode (MODE=8'h04): one 3-cycle low pulse on src_n[2] -> PENDING=8'h04 stays after release. Write PENDING=8'h04 -> cleared, irq_n high 2 edges after commit.
- Simultaneous: edge on channel 2 in the same cycle as its W1C commit -> PENDING bit stays 1.
- Write handshake: a 10-cycle write to MASK with data_in changing from 8'h00 to 8'h01 on the last cycle -> MASK=8'h01 committed once, one cycle after cs_n rises.
- MASK=0 with all sources low -> irq_n=1 and STATUS=8'h07. FORCE=8'h07 with MODE=8'h01 -> PENDING bit0 only. Reset pulsed mid-write -> no commit.
